// File: rtl/instr_encoder_pkg.sv
// Package enc_pkg: opcode, funct and ALU-operation constants shared by the
// instruction encoder, plus the result type of the combinational encoder.
package enc_pkg;

    // Opcode space
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_IMM   = 6'h3F;

    // R-type funct codes
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_OR  = 6'h25;

    // Requested ALU operation codes
    localparam logic [3:0] ALU_ANDI = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;

    // Encoder result: legality flag plus the encoded word
    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Interface instr_encoder_if: request side, issue side and status signals of
// the instruction encoder.
//   slave  modport : encoder view (requests in, words/status out)
//   master modport : producer/consumer view
interface instr_encoder_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) ();
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_op;
    logic             in_imm_sel;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [4:0]       in_shamt;
    logic [15:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err_illegal;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] issued_cnt;

    modport slave (
        input  in_valid, in_alu_op, in_imm_sel, in_rs, in_rt, in_rd, in_shamt,
               in_imm, out_ready,
        output in_ready, out_valid, out_instr, err_illegal, level, issued_cnt
    );

    modport master (
        output in_valid, in_alu_op, in_imm_sel, in_rs, in_rt, in_rd, in_shamt,
               in_imm, out_ready,
        input  in_ready, out_valid, out_instr, err_illegal, level, issued_cnt
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: synchronous FIFO with asynchronous active-high reset.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst      clock, async reset
//   push_i        write wdata_i (caller guarantees !full_o)
//   wdata_i       write data
//   pop_i         drop the head entry (ignored when empty)
//   rdata_o       head entry, 0 when empty
//   full_o        FIFO full
//   empty_o       FIFO empty
//   level_o       occupancy
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == {LVL_W{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign level_o   = level_q;
    // Head is gated so stale storage never leaks out after a reset
    assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset because the head is gated by empty
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoded control requests into 32-bit instruction
// words, buffers them in instr_fifo, drops illegal requests with a one-cycle
// err_illegal pulse, and counts issued words.
// Ports:
//   clk, rst   single clock, asynchronous active-high reset
//   bus        instr_encoder_if.slave: request handshake and fields, issue
//              handshake and word, err_illegal, level, issued_cnt
module instr_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_encoder_if.slave     bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    enc_result_t      enc_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [31:0]      head_s;
    logic [LVL_W-1:0] level_s;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational encoder; anything not listed is illegal
    always_comb begin
        enc_s.legal = 1'b0;
        enc_s.word  = 32'h0000_0000;
        if (bus.in_imm_sel) begin
            if (bus.in_alu_op == ALU_ANDI) begin
                enc_s.legal = 1'b1;
                enc_s.word  = {OP_IMM, bus.in_rs, bus.in_rt, bus.in_imm};
            end else begin
                enc_s.legal = 1'b0;
            end
        end else begin
            case (bus.in_alu_op)
                ALU_ADD: begin
                    enc_s.legal = 1'b1;
                    enc_s.word  = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, F_ADD};
                end
                ALU_SUB: begin
                    enc_s.legal = 1'b1;
                    enc_s.word  = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, F_SUB};
                end
                ALU_OR: begin
                    enc_s.legal = 1'b1;
                    enc_s.word  = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, F_OR};
                end
                // Shifts take their operand from rt; rs is not part of the encoding
                ALU_SLL: begin
                    enc_s.legal = 1'b1;
                    enc_s.word  = {OP_RTYPE, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, F_SLL};
                end
                ALU_SRL: begin
                    enc_s.legal = 1'b1;
                    enc_s.word  = {OP_RTYPE, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, F_SRL};
                end
                default: begin
                    enc_s.legal = 1'b0;
                end
            endcase
        end
    end

    // in_ready depends only on registered occupancy, so a same-cycle pop
    // never lets a push through a full FIFO
    assign accept_s = bus.in_valid && !full_s;
    assign push_s   = accept_s && enc_s.legal;
    assign pop_s    = !empty_s && bus.out_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (enc_s.word),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Next-state for the illegal pulse and issue counter
    always_comb begin
        err_d = accept_s && !enc_s.legal;
        cnt_d = cnt_q;
        if (pop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Illegal-pulse and issue-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready    = !full_s;
    assign bus.out_valid   = !empty_s;
    assign bus.out_instr   = head_s;
    assign bus.err_illegal = err_q;
    assign bus.level       = level_s;
    assign bus.issued_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder. Two instances share the same
// stimulus: u0 with CNT_W=16 and u1 with CNT_W=4 (counter wrap).
module tb_instr_encoder;
    import enc_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instr_encoder_if #(.DEPTH(4), .CNT_W(16)) bus0 ();
    instr_encoder_if #(.DEPTH(4), .CNT_W(4))  bus1 ();

    instr_encoder #(.DEPTH(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    instr_encoder #(.DEPTH(4), .CNT_W(4))  u1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.in_valid   = bus0.in_valid;
    assign bus1.in_alu_op  = bus0.in_alu_op;
    assign bus1.in_imm_sel = bus0.in_imm_sel;
    assign bus1.in_rs      = bus0.in_rs;
    assign bus1.in_rt      = bus0.in_rt;
    assign bus1.in_rd      = bus0.in_rd;
    assign bus1.in_shamt   = bus0.in_shamt;
    assign bus1.in_imm     = bus0.in_imm;
    assign bus1.out_ready  = bus0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic isel,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm);
        bus0.in_valid   = v;
        bus0.in_alu_op  = op;
        bus0.in_imm_sel = isel;
        bus0.in_rs      = rs;
        bus0.in_rt      = rt;
        bus0.in_rd      = rd;
        bus0.in_shamt   = sh;
        bus0.in_imm     = imm;
    endtask

    // Push one request, check the head the cycle after, then pop it
    task automatic push_pop(input string tag, input logic [3:0] op, input logic isel,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [4:0] sh, input logic [15:0] imm,
                            input logic [31:0] exp_word, input logic [15:0] exp_cnt);
        drive(1'b1, op, isel, rs, rt, rd, sh, imm);
        chk({tag, "_no_bypass"}, {31'd0, bus0.out_valid}, 32'd0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk({tag, "_valid"}, {31'd0, bus0.out_valid}, 32'd1);
        chk({tag, "_word"}, bus0.out_instr, exp_word);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        chk({tag, "_cnt"}, {16'd0, bus0.issued_cnt}, {16'd0, exp_cnt});
        chk({tag, "_empty"}, {29'd0, bus0.level}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.out_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_out_instr", bus0.out_instr, 32'h0);
        chk("rst_err", {31'd0, bus0.err_illegal}, 32'd0);
        chk("rst_level", {29'd0, bus0.level}, 32'd0);
        chk("rst_cnt", {16'd0, bus0.issued_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", {31'd0, bus0.in_ready}, 32'd1);

        // Legal encodings
        push_pop("add", ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 32'h0022_1820, 16'd1);
        push_pop("sub", ALU_SUB, 1'b0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 32'h0085_3022, 16'd2);
        push_pop("sll", ALU_SLL, 1'b0, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 32'h0002_1900, 16'd3);
        push_pop("imm", ALU_ANDI, 1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 32'hFC22_1234, 16'd4);
        push_pop("or", ALU_OR, 1'b0, 5'd3, 5'd4, 5'd5, 5'd7, 16'h0, 32'h0064_2825, 16'd5);
        push_pop("srl", ALU_SRL, 1'b0, 5'd31, 5'd1, 5'd2, 5'd5, 16'h0, 32'h0001_1142, 16'd6);

        // Illegal: alu_op 0x7 and imm_sel=1 with alu_op 0x2
        drive(1'b1, 4'h7, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        chk("ill1_ready", {31'd0, bus0.in_ready}, 32'd1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("ill1_err", {31'd0, bus0.err_illegal}, 32'd1);
        chk("ill1_level", {29'd0, bus0.level}, 32'd0);
        chk("ill1_valid", {31'd0, bus0.out_valid}, 32'd0);
        tick();
        chk("ill1_err_clr", {31'd0, bus0.err_illegal}, 32'd0);
        drive(1'b1, ALU_ADD, 1'b1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h5555);
        tick();
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("ill2_err", {31'd0, bus0.err_illegal}, 32'd1);
        chk("ill2_level", {29'd0, bus0.level}, 32'd0);
        tick();
        chk("ill2_err_clr", {31'd0, bus0.err_illegal}, 32'd0);
        chk("ill_cnt", {16'd0, bus0.issued_cnt}, 32'd6);

        // Fill to full with out_ready=0: add rs=1 rt=2 rd=1..4
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'(k), 5'd0, 16'h0);
            tick();
        end
        chk("full_level", {29'd0, bus0.level}, 32'd4);
        chk("full_ready", {31'd0, bus0.in_ready}, 32'd0);
        chk("full_head", bus0.out_instr, 32'h0022_0820);
        // Pop with a pending request: no push-through
        drive(1'b1, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0);
        bus0.out_ready = 1'b1;
        tick();
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("pop_full_level", {29'd0, bus0.level}, 32'd3);
        chk("pop_full_ready", {31'd0, bus0.in_ready}, 32'd1);
        chk("drain_w2", bus0.out_instr, 32'h0022_1020);
        tick();
        chk("drain_w3", bus0.out_instr, 32'h0022_1820);
        tick();
        chk("drain_w4", bus0.out_instr, 32'h0022_2020);
        chk("drain_lvl1", {29'd0, bus0.level}, 32'd1);
        tick();
        chk("drain_empty_instr", bus0.out_instr, 32'h0);
        chk("drain_empty_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("drain_cnt", {16'd0, bus0.issued_cnt}, 32'd10);
        bus0.out_ready = 1'b0;

        // Restart counters, then 20 cycles of simultaneous push and pop
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_cnt", {16'd0, bus0.issued_cnt}, 32'd0);
        drive(1'b1, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0);
        tick();
        bus0.out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0);
            tick();
            w = 32'h0022_0020 | (32'(i) << 11);
            chk($sformatf("stream_level_%0d", i), {29'd0, bus0.level}, 32'd1);
            chk($sformatf("stream_word_%0d", i), bus0.out_instr, w);
            chk($sformatf("stream_cnt4_%0d", i), {28'd0, bus1.issued_cnt}, 32'(i % 16));
        end
        chk("stream_cnt16", {16'd0, bus0.issued_cnt}, 32'd20);
        chk("stream_cnt4_wrap", {28'd0, bus1.issued_cnt}, 32'd4);
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();
        bus0.out_ready = 1'b0;
        chk("stream_final_level", {29'd0, bus0.level}, 32'd0);
        chk("stream_final_cnt", {16'd0, bus0.issued_cnt}, 32'd21);

        // Asynchronous reset with level=3
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, ALU_SUB, 1'b0, 5'd4, 5'd5, 5'(k), 5'd0, 16'h0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        chk("pre_arst_level", {29'd0, bus0.level}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("arst_level", {29'd0, bus0.level}, 32'd0);
        chk("arst_instr", bus0.out_instr, 32'h0);
        chk("arst_cnt", {16'd0, bus0.issued_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        chk("arst_ready", {31'd0, bus0.in_ready}, 32'd1);
        push_pop("post_arst", ALU_OR, 1'b0, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 32'h0064_2825, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
